forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL provide parameter: REG_AW, 5, register-address width.
REQ-002 SHALL provide parameter: DATA_W, 32, operand width of the forwarding muxes it drives (informational; no datapath inside).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port: id_valid  in  1  ID-stage instruction present.
REQ-007 SHALL have port: id_rs1, id_rs2  in  REG_AW  ID source registers.
REQ-008 SHALL have port: id_rd  in  REG_AW  ID destination register.
REQ-009 SHALL have port: id_reg_write  in  1  ID instruction writes rd.
REQ-010 SHALL have port: id_mem_read  in  1  ID instruction is a load.
REQ-011 SHALL have port: flush  in  1  kill ID instruction (branch redirect).
REQ-012 SHALL have port: fwd_a_sel, fwd_b_sel  out  2  select for EX operand A/B 3-to-1 mux: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-013 SHALL have port: stall  out  1  load-use hazard; hold PC and IF/ID.
REQ-014 SHALL have port: stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-015 SHALL keep three internal stage records EX, MEM, WB, each holding {valid, rs1, rs2, rd, reg_write, mem_read}; MEM and WB need only {valid, rd, reg_write}.
REQ-016 SHALL advance every clock: WB <- MEM, MEM <- EX, EX <- ID record.
REQ-017 SHALL load a bubble (valid=0, all fields 0) into EX when stall=1 or flush=1 instead of the ID record; MEM/WB advance regardless.
REQ-018 SHALL compute stall = id_valid & ~flush & EX.valid & EX.mem_read & (EX.rd != 0) & ((EX.rd == id_rs1) | (EX.rd == id_rs2)), combinational, same cycle.
REQ-019 SHALL drive fwd_a_sel combinationally from registered state only: 01 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1; else 10 if the same holds for WB; else 00.
REQ-020 SHALL drive fwd_b_sel identically using EX.rs2.
REQ-021 SHALL give MEM priority over WB when both match (newest value wins).
REQ-022 SHALL never forward register 0; SHALL never output 11.
REQ-023 SHALL drive 00 on both selects when EX.valid = 0.
REQ-024 SHALL increment stall_cnt by 1 on each clock where stall=1, saturating at 16'hFFFF (no wrap).
REQ-025 SHALL let flush suppress stall in the same cycle; flush and stall never both cause a bubble twice (a single bubble per cycle).
REQ-026 SHALL treat id_* inputs as don't-care when id_valid = 0 (record enters EX with valid=0).

Reset
REQ-027 SHALL on a clock edge with rst=1 clear EX, MEM, WB to bubbles and clear stall_cnt to 0; rst overrides stall and flush.
REQ-028 SHALL produce fwd_a_sel = fwd_b_sel = 00 and stall = 0 in the cycle after reset and until a valid writer reaches MEM.
REQ-029 SHALL discard in-flight records when rst asserts mid-operation; no forwarding from pre-reset instructions afterwards.

Verification
REQ-030 SHALL verify EX->EX forward: issue rd=5 writer, then rs1=5 reader next cycle -> when reader in EX, fwd_a_sel=01, fwd_b_sel=00.
REQ-031 SHALL verify MEM->EX forward and priority: writers to x7 at t and t+1, reader rs2=7 at t+2 -> fwd_b_sel=01 (not 10); with only the t writer, fwd_b_sel=10.
REQ-032 SHALL verify load-use: load rd=3 followed by rs1=3 -> stall=1 for exactly one cycle, EX bubble, then fwd_a_sel=10, stall_cnt=1.
REQ-033 SHALL verify x0: writer rd=0 then reader rs1=0 -> fwd_a_sel=00; load rd=0 followed by rs1=0 -> stall=0.
REQ-034 SHALL verify flush: load rd=4 in EX, id_rs1=4, flush=1 -> stall=0, EX bubble next cycle, stall_cnt unchanged.
REQ-035 SHALL verify saturation/reset: force 65 537 stall cycles -> stall_cnt=16'hFFFF; assert rst -> stall_cnt=0, selects 00 next cycle.

Source files
------------

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB register-usage records and drives the EX operand mux
// selects, the load-use stall, and a saturating stall-cycle counter.
module forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [15:0]       stall_cnt
);

  // DATA_W only documents the mux width this block steers; reject nonsense values.
  if (DATA_W < 1 || REG_AW < 1) begin : g_bad_param
    $error("forward_ctrl: REG_AW and DATA_W must be positive");
  end

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_rec_t;

  // Later stages only need to know who writes what.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } wr_rec_t;

  ex_rec_t ex_r;
  wr_rec_t mem_r, wb_r;
  ex_rec_t id_rec;
  logic    hazard;

  // Stage writers that actually produce a usable (non-x0) result.
  logic mem_wr, wb_wr;
  assign mem_wr = mem_r.valid & mem_r.reg_write & (mem_r.rd != '0);
  assign wb_wr  = wb_r.valid  & wb_r.reg_write  & (wb_r.rd  != '0);

  // Load in EX whose result the ID instruction needs: hold one cycle. A flush
  // already kills the ID instruction, so it masks the hazard.
  always_comb begin
    hazard = id_valid & ~flush & ex_r.valid & ex_r.mem_read & (ex_r.rd != '0)
             & ((ex_r.rd == id_rs1) | (ex_r.rd == id_rs2));
  end

  assign stall = hazard;

  // Operand selects from registered state only; MEM wins as the newer value.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (ex_r.valid) begin
      if (mem_wr && mem_r.rd == ex_r.rs1)     fwd_a_sel = SEL_MEM;
      else if (wb_wr && wb_r.rd == ex_r.rs1)  fwd_a_sel = SEL_WB;
      if (mem_wr && mem_r.rd == ex_r.rs2)     fwd_b_sel = SEL_MEM;
      else if (wb_wr && wb_r.rd == ex_r.rs2)  fwd_b_sel = SEL_WB;
    end
  end

  // Record entering EX; invalid ID slots become full-zero bubbles.
  always_comb begin
    id_rec = '0;
    if (id_valid) begin
      id_rec.valid     = 1'b1;
      id_rec.rs1       = id_rs1;
      id_rec.rs2       = id_rs2;
      id_rec.rd        = id_rd;
      id_rec.reg_write = id_reg_write;
      id_rec.mem_read  = id_mem_read;
    end
  end

  // Pipeline advance: stall or flush inject a single bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      wb_r            <= mem_r;
      mem_r.valid     <= ex_r.valid;
      mem_r.rd        <= ex_r.rd;
      mem_r.reg_write <= ex_r.reg_write;
      ex_r            <= (hazard || flush) ? '0 : id_rec;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt <= '0;
    else if (hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// Scenario bench for forward_ctrl: each task drives a short instruction
// sequence, queues the expected outputs per cycle and checks them mid-cycle.
module tb_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_mem_read, flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic v; logic [4:0] r1, r2, d; logic w, m, fl, rs;
  } instr_t;

  typedef struct packed {
    logic chk; logic [1:0] a, b; logic st; logic cc; logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  forward_ctrl #(.REG_AW(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  function automatic instr_t mk_i(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                                  logic w, logic m, logic fl = 1'b0, logic rs = 1'b0);
    return '{v: v, r1: r1, r2: r2, d: d, w: w, m: m, fl: fl, rs: rs};
  endfunction

  function automatic exp_t mk_e(logic chk, logic [1:0] a, logic [1:0] b, logic st,
                                logic cc = 1'b0, logic [15:0] cnt = 16'h0);
    return '{chk: chk, a: a, b: b, st: st, cc: cc, cnt: cnt};
  endfunction

  task automatic drv(input instr_t t);
    id_valid = t.v; id_rs1 = t.r1; id_rs2 = t.r2; id_rd = t.d;
    id_reg_write = t.w; id_mem_read = t.m; flush = t.fl; rst = t.rs;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drv(mk_i(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(); cyc();
    drv(mk_i(0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    instr_t s[$]; exp_t x[$]; exp_t e;
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(1, 3, 3, 4, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL reset[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_ex_fwd();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    s.push_back(mk_i(1, 0, 0, 5, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 5, 6, 8, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b01, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 0, 0, 5, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 6, 5, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b01, 0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL ex_fwd[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_mem_fwd();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    // two writers to x7 back to back: newest (MEM) must win
    s.push_back(mk_i(1, 0, 0, 7, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 0, 0, 7, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 1, 7, 2, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b01, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    // single writer two ahead: WB forward
    s.push_back(mk_i(1, 0, 0, 7, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 1, 7, 2, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b10, 0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL mem_fwd[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_load_use();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    s.push_back(mk_i(1, 0, 0, 3, 1, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(1, 3, 0, 4, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 1, 1, 16'd0));
    s.push_back(mk_i(1, 3, 0, 4, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd1));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b10, 2'b00, 0, 1, 16'd1));
    // hazard through rs2
    s.push_back(mk_i(1, 0, 0, 3, 1, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd1));
    s.push_back(mk_i(1, 0, 3, 4, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 1, 1, 16'd1));
    s.push_back(mk_i(1, 0, 3, 4, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd2));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b10, 0, 1, 16'd2));
    // invalid ID slot never stalls even if its fields match
    s.push_back(mk_i(1, 0, 0, 3, 1, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd2));
    s.push_back(mk_i(0, 3, 3, 9, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd2));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd2));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL load_use[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_x0();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    s.push_back(mk_i(1, 0, 0, 0, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 0, 0, 1, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 0, 0, 0, 1, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 0, 0, 1, 1, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL x0[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_flush();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    s.push_back(mk_i(1, 0, 0, 4, 1, 1));     x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(1, 4, 0, 5, 1, 0, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    // EX.valid=0 gates forwarding even when fields match
    s.push_back(mk_i(1, 0, 0, 5, 1, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 5, 5, 9, 1, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    // flush of a plain reader still bubbles EX
    s.push_back(mk_i(1, 0, 0, 6, 1, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 6, 6, 9, 1, 0, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));     x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL flush[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_mid_reset();
    instr_t s[$]; exp_t x[$]; exp_t e;
    do_reset();
    s.push_back(mk_i(1, 0, 0, 9, 1, 0));        x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 9, 0, 2, 1, 0, 0, 1));  x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 9, 0, 2, 1, 0));        x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(0, 0, 0, 0, 0, 0));        x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    s.push_back(mk_i(1, 0, 0, 3, 1, 1));        x.push_back(mk_e(1, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 3, 0, 2, 1, 0, 0, 1));  x.push_back(mk_e(0, 2'b00, 2'b00, 0));
    s.push_back(mk_i(1, 3, 0, 2, 1, 0));        x.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    for (int k = 0; k < s.size(); k++) begin
      drv(s[k]); exp_q.push_back(x[k]);
      @(negedge clk); e = exp_q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || (e.cc && stall_cnt !== e.cnt)) begin
          n_bad++;
          $display("FAIL mid_reset[%0d]: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
                   k, fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
        end
      end
      cyc();
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    // Hold the hazard asserted so every clock is a stall cycle.
    force dut.hazard = 1'b1;
    repeat (65534) cyc();
    exp_q.push_back(mk_e(1, 2'b00, 2'b00, 1, 1, 16'hFFFE));
    @(negedge clk); e = exp_q.pop_front();
    n_cmp++;
    if (stall_cnt !== e.cnt || stall !== e.st) begin
      n_bad++;
      $display("FAIL sat_65534: got cnt=%h stall=%b, want cnt=%h stall=%b", stall_cnt, stall, e.cnt, e.st);
    end
    repeat (3) cyc();
    exp_q.push_back(mk_e(1, 2'b00, 2'b00, 1, 1, 16'hFFFF));
    @(negedge clk); e = exp_q.pop_front();
    n_cmp++;
    if (stall_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL sat_65537: got cnt=%h, want cnt=%h", stall_cnt, e.cnt);
    end
    release dut.hazard;
    // writer then reader, reset lands while the reader is in ID
    drv(mk_i(1, 0, 0, 5, 1, 0));
    cyc();
    drv(mk_i(1, 5, 5, 2, 1, 0, 0, 1));
    exp_q.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'hFFFF));
    @(negedge clk); e = exp_q.pop_front();
    n_cmp++;
    if (stall_cnt !== e.cnt || stall !== e.st) begin
      n_bad++;
      $display("FAIL sat_hold: got cnt=%h stall=%b, want cnt=%h stall=%b", stall_cnt, stall, e.cnt, e.st);
    end
    cyc();
    drv(mk_i(0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk_e(1, 2'b00, 2'b00, 0, 1, 16'd0));
    @(negedge clk); e = exp_q.pop_front();
    n_cmp++;
    if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st} || stall_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL sat_reset: got a=%b b=%b stall=%b cnt=%h, want a=%b b=%b stall=%b cnt=%h",
               fwd_a_sel, fwd_b_sel, stall, stall_cnt, e.a, e.b, e.st, e.cnt);
    end
    cyc();
  endtask

  initial begin
    drv(mk_i(1, 3, 3, 3, 1, 1, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_x0();
    test_flush();
    test_mid_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
